// File: rtl/gig_ethernet_pcs_pma_pkg.sv
// Shared types, default timing constants and helpers for the PCS/PMA reset sequencer.
package gig_ethernet_pcs_pma_pkg;

  localparam int unsigned DefPllRstCycles = 64;
  localparam int unsigned DefPcsRstCycles = 16;
  localparam int unsigned DefWaitTimeout  = 131072;
  localparam int unsigned DefSyncStages   = 3;

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StPllWait  = 3'd1,
    StGtWait   = 3'd2,
    StMmcmWait = 3'd3,
    StPcsRst   = 3'd4,
    StDone     = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic pll_reset;
    logic gt_tx_reset;
    logic gt_rx_reset;
    logic mmcm_reset;
    logic pcs_reset;
    logic reset_done;
  } rst_out_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

  // Reset pin levels driven while sitting in a given state.
  function automatic rst_out_t state_outputs(input seq_state_e st);
    rst_out_t o;
    o.pll_reset   = 1'b1;
    o.gt_tx_reset = 1'b1;
    o.gt_rx_reset = 1'b1;
    o.mmcm_reset  = 1'b1;
    o.pcs_reset   = 1'b1;
    o.reset_done  = 1'b0;
    case (st)
      StPllWait: o.pll_reset = 1'b0;
      StGtWait: begin
        o.pll_reset   = 1'b0;
        o.gt_tx_reset = 1'b0;
        o.gt_rx_reset = 1'b0;
      end
      StMmcmWait, StPcsRst: begin
        o.pll_reset   = 1'b0;
        o.gt_tx_reset = 1'b0;
        o.gt_rx_reset = 1'b0;
        o.mmcm_reset  = 1'b0;
      end
      StDone: begin
        o.pll_reset   = 1'b0;
        o.gt_tx_reset = 1'b0;
        o.gt_rx_reset = 1'b0;
        o.mmcm_reset  = 1'b0;
        o.pcs_reset   = 1'b0;
        o.reset_done  = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/gig_ethernet_pcs_pma_status_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous status inputs; resets to 0.
module gig_ethernet_pcs_pma_status_sync
  import gig_ethernet_pcs_pma_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned WIDTH       = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gig_ethernet_pcs_pma_reset_seq.sv
// Shared-logic reset sequencer: PLL -> GT TX/RX -> MMCM -> PCS, restarting on lock loss.
// Define GIG_RESET_SEQ_TIMEOUT_RETRY_EN to restart the sequence on any WAIT timeout.
module gig_ethernet_pcs_pma_reset_seq
  import gig_ethernet_pcs_pma_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DefPllRstCycles,
  parameter int unsigned PCS_RST_CYCLES = DefPcsRstCycles,
  parameter int unsigned WAIT_TIMEOUT   = DefWaitTimeout,
  parameter int unsigned SYNC_STAGES    = DefSyncStages
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pll_lock_i,
  input  logic       mmcm_locked_i,
  input  logic       tx_resetdone_i,
  input  logic       rx_resetdone_i,
  output logic       pll_reset_o,
  output logic       gt_tx_reset_o,
  output logic       gt_rx_reset_o,
  output logic       mmcm_reset_o,
  output logic       pcs_reset_o,
  output logic       reset_done_o,
  output logic       timeout_flag_o,
  output logic [2:0] state_dbg_o
);

  localparam int unsigned CntW = cnt_width(PLL_RST_CYCLES, PCS_RST_CYCLES, WAIT_TIMEOUT);
  localparam logic [CntW-1:0] CntMax     = '1;
  localparam logic [CntW-1:0] PllRstLast = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] PcsRstLast = CntW'(PCS_RST_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLast   = CntW'(WAIT_TIMEOUT - 1);

  logic [3:0] status_s;
  logic       pll_lock_s, mmcm_locked_s, tx_done_s, rx_done_s;

  gig_ethernet_pcs_pma_status_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (4)
  ) u_status_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .async_i({mmcm_locked_i, rx_resetdone_i, tx_resetdone_i, pll_lock_i}),
    .sync_o (status_s)
  );

  assign {mmcm_locked_s, rx_done_s, tx_done_s, pll_lock_s} = status_s;

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  rst_out_t        out_q;
  logic            timeout_q, timeout_d;
  logic            in_wait, timeout_hit;

  always_comb begin
    state_d = state_q;
    in_wait = 1'b0;
    unique case (state_q)
      StPllRst:   if (cnt_q == PllRstLast) state_d = StPllWait;
      StPllWait: begin
        in_wait = 1'b1;
        if (pll_lock_s) state_d = StGtWait;
      end
      StGtWait: begin
        in_wait = 1'b1;
        if (tx_done_s && rx_done_s) state_d = StMmcmWait;
      end
      StMmcmWait: begin
        in_wait = 1'b1;
        if (mmcm_locked_s) state_d = StPcsRst;
      end
      StPcsRst:   if (cnt_q == PcsRstLast) state_d = StDone;
      StDone:     ;
      default:    state_d = StPllRst;
    endcase

    // Lock loss overrides normal progress; PLL loss wins over MMCM loss.
    if ((state_q == StPcsRst || state_q == StDone) && !mmcm_locked_s) state_d = StMmcmWait;
    if (state_q != StPllRst && state_q != StPllWait && !pll_lock_s) state_d = StPllRst;

    // A timeout only counts when the state is not already being left this cycle.
    timeout_hit = in_wait && (state_d == state_q) && (cnt_q == WaitLast);
`ifdef GIG_RESET_SEQ_TIMEOUT_RETRY_EN
    if (timeout_hit) state_d = StPllRst;
`endif

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    timeout_d = timeout_q | timeout_hit;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      out_q     <= state_outputs(StPllRst);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= state_outputs(state_d);
      timeout_q <= timeout_d;
    end
  end

  assign pll_reset_o    = out_q.pll_reset;
  assign gt_tx_reset_o  = out_q.gt_tx_reset;
  assign gt_rx_reset_o  = out_q.gt_rx_reset;
  assign mmcm_reset_o   = out_q.mmcm_reset;
  assign pcs_reset_o    = out_q.pcs_reset;
  assign reset_done_o   = out_q.reset_done;
  assign timeout_flag_o = timeout_q;
  assign state_dbg_o    = state_q;

endmodule
